// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
//   Shared types and helpers for the LED mode sequencer.
//   - state_e : sequencer FSM states
//   - req_e   : a mode-change request (none / next / prev)
//   - LED_OFF : all eight active-low LEDs dark
//   - pick_req()  : resolves coincident button pulses (next wins over prev)
//   - step_sel()  : modular next/previous mode index
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_NEXT = 2'd1,
    REQ_PREV = 2'd2
  } req_e;

  localparam logic [7:0] LED_OFF = 8'hFF;

  // Button pulses arriving in the same cycle: next beats prev.
  function automatic req_e pick_req(input logic nxt, input logic prv);
    if (nxt) return REQ_NEXT;
    if (prv) return REQ_PREV;
    return REQ_NONE;
  endfunction

  // Mode index after one step in the given direction, wrapping at both ends.
  function automatic int step_sel(input int sel, input int num_modes, input req_e dir);
    if (dir == REQ_PREV) return (sel == 0) ? num_modes - 1 : sel - 1;
    return (sel == num_modes - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/led_fade_gate.sv
// -----------------------------------------------------------------------------
// led_fade_gate
//   PWM brightness gate for the active-low LED bus. A free-running counter
//   sweeps 0..PWM_PERIOD-1; the LEDs pass through while the counter is below
//   level*(PWM_PERIOD/FADE_STEPS), otherwise they are forced dark. The result
//   is registered, so led_out lags its inputs by one clock.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   level    in   brightness, 0 (dark) .. FADE_STEPS (full pass-through)
//   led_in   in   [7:0] selected driver pattern (active-low)
//   led_out  out  [7:0] gated pattern (active-low), registered
// -----------------------------------------------------------------------------
module led_fade_gate
  import led_pkg::*;
#(
  parameter  int PWM_PERIOD = 2400,
  parameter  int FADE_STEPS = 16,
  localparam int LEVEL_W    = $clog2(FADE_STEPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level,
  input  logic [7:0]         led_in,
  output logic [7:0]         led_out
);

  // Wide enough to hold PWM_PERIOD itself, which is the full-brightness threshold.
  localparam int PWM_W = $clog2(PWM_PERIOD + 1);
  localparam int TICKS_PER_LEVEL = PWM_PERIOD / FADE_STEPS;
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [PWM_W-1:0] thresh;
  logic [7:0]       led_q, led_d;

  always_comb begin
    pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_W'(1);
    thresh = PWM_W'(level) * PWM_W'(TICKS_PER_LEVEL);
    led_d  = (pwm_q < thresh) ? led_in : LED_OFF;
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
      led_q <= LED_OFF;
    end else begin
      pwm_q <= pwm_d;
      led_q <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//   Chooses which of NUM_MODES LED drivers owns the eight board LEDs and
//   crossfades between them: fade out, swap the selection (pulsing the new
//   driver's restart), fade back in. Mode changes come from next/prev button
//   pulses or from a dwell timer when auto_en is high. Requests that arrive
//   during a crossfade are held in a one-deep pending slot (latest wins) and
//   start the next crossfade as soon as the current fade-in completes.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   btn_next      in   1-cycle pulse, request next mode
//   btn_prev      in   1-cycle pulse, request previous mode
//   auto_en       in   level, enables dwell-timer auto-advance
//   mode_led      in   [8*NUM_MODES-1:0] driver outputs, mode m at [8m+7:8m]
//   led_out       out  [7:0] gated, muxed LED drive (active-low)
//   mode_sel      out  index of the mode currently displayed
//   mode_restart  out  [NUM_MODES-1:0] one-hot restart pulse in the SWAP cycle
//   busy          out  high in FADE_OUT / SWAP / FADE_IN
// -----------------------------------------------------------------------------
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter  int NUM_MODES       = 4,
  parameter  int PWM_PERIOD      = 2400,
  parameter  int FADE_STEPS      = 16,
  parameter  int FADE_STEP_TICKS = 2400,
  parameter  int DWELL_TICKS     = 24_000_000,
  localparam int SEL_W           = $clog2(NUM_MODES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_next,
  input  logic                   btn_prev,
  input  logic                   auto_en,
  input  logic [8*NUM_MODES-1:0] mode_led,
  output logic [7:0]             led_out,
  output logic [SEL_W-1:0]       mode_sel,
  output logic [NUM_MODES-1:0]   mode_restart,
  output logic                   busy
);

  localparam int LEVEL_W = $clog2(FADE_STEPS + 1);
  localparam int STEP_W  = $clog2(FADE_STEP_TICKS + 1);
  localparam int DWELL_W = $clog2(DWELL_TICKS + 1);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(FADE_STEPS);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(FADE_STEP_TICKS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

  state_e             state_q,    state_d;
  logic [LEVEL_W-1:0] level_q,    level_d;
  logic [STEP_W-1:0]  step_q,     step_d;
  logic [DWELL_W-1:0] dwell_q,    dwell_d;
  req_e               dir_q,      dir_d;      // direction of the crossfade in flight
  req_e               pending_q,  pending_d;
  logic [SEL_W-1:0]   mode_sel_q, mode_sel_d;

  req_e       btn_req;
  req_e       run_req;
  req_e       resume_req;
  logic       step_last;
  logic       dwell_exp;
  logic [7:0] led_mux;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FADE_IN;
      level_q    <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      dir_q      <= REQ_NONE;
      pending_q  <= REQ_NONE;
      mode_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      dir_q      <= dir_d;
      pending_q  <= pending_d;
      mode_sel_q <= mode_sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    level_d    = level_q;
    step_d     = '0;
    dwell_d    = '0;
    dir_d      = dir_q;
    pending_d  = pending_q;
    mode_sel_d = mode_sel_q;

    btn_req    = pick_req(btn_next, btn_prev);
    dwell_exp  = auto_en && (dwell_q == DWELL_LAST);
    run_req    = (btn_req != REQ_NONE) ? btn_req : (dwell_exp ? REQ_NEXT : REQ_NONE);
    // A button in the last fade-in cycle is newer than whatever is pending.
    resume_req = (btn_req != REQ_NONE) ? btn_req : pending_q;
    step_last  = (step_q == STEP_LAST);

    unique case (state_q)
      RUN: begin
        if (run_req != REQ_NONE) begin
          state_d = FADE_OUT;
          dir_d   = run_req;
        end else if (auto_en) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      FADE_OUT: begin
        if (btn_req != REQ_NONE) pending_d = btn_req;
        step_d = step_last ? '0 : step_q + STEP_W'(1);
        if (step_last) begin
          if (level_q <= LEVEL_ONE) begin
            level_d    = '0;
            state_d    = SWAP;
            // Selection changes on entry to SWAP so the restart pulse and the
            // displayed index agree during the SWAP cycle.
            mode_sel_d = SEL_W'(step_sel(int'(mode_sel_q), NUM_MODES, dir_q));
          end else begin
            level_d = level_q - LEVEL_ONE;
          end
        end
      end

      SWAP: begin
        if (btn_req != REQ_NONE) pending_d = btn_req;
        state_d = FADE_IN;
      end

      FADE_IN: begin
        if (btn_req != REQ_NONE) pending_d = btn_req;
        step_d = step_last ? '0 : step_q + STEP_W'(1);
        if (step_last) begin
          if (level_q >= LEVEL_MAX - LEVEL_ONE) begin
            level_d = LEVEL_MAX;
            if (resume_req != REQ_NONE) begin
              // Queued request: skip RUN and start the next crossfade directly.
              state_d   = FADE_OUT;
              dir_d     = resume_req;
              pending_d = REQ_NONE;
            end else begin
              state_d = RUN;
            end
          end else begin
            level_d = level_q + LEVEL_ONE;
          end
        end
      end

      default: state_d = FADE_IN;
    endcase

    // The step counter restarts on every state entry.
    if (state_d != state_q) step_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != RUN);
    mode_sel     = mode_sel_q;
    mode_restart = '0;
    if (state_q == SWAP) mode_restart[mode_sel_q] = 1'b1;
  end

  // The gate sees the next-cycle selection and level: its output register then
  // lines up with the state/mode_sel values visible in the same cycle, which
  // keeps the LEDs dark throughout SWAP.
  always_comb begin
    led_mux = LED_OFF;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_sel_d == SEL_W'(m)) led_mux = mode_led[8*m +: 8];
    end
  end

  led_fade_gate #(
    .PWM_PERIOD (PWM_PERIOD),
    .FADE_STEPS (FADE_STEPS)
  ) u_gate (
    .clk     (clk),
    .rst     (rst),
    .level   (level_d),
    .led_in  (led_mux),
    .led_out (led_out)
  );

endmodule

// File: tb/tb_led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sequencer
//   Self-checking bench. A timeline model (phase + cycles elapsed in phase,
//   brightness derived from elapsed time) predicts every output each cycle;
//   directed sequences add hand-computed literal expectations, then a random
//   phase exercises buttons, pending requests and auto-advance.
// -----------------------------------------------------------------------------
module tb_led_mode_sequencer;

  localparam int NM   = 4;
  localparam int P    = 16;
  localparam int S    = 4;
  localparam int T    = 16;
  localparam int DW   = 200;
  localparam int FADE_LEN = S * T;

  localparam int PH_RUN  = 0;
  localparam int PH_OUT  = 1;
  localparam int PH_SWAP = 2;
  localparam int PH_IN   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_next;
  logic            btn_prev;
  logic            auto_en;
  logic [8*NM-1:0] mode_led;
  logic [7:0]      led_out;
  logic [1:0]      mode_sel;
  logic [NM-1:0]   mode_restart;
  logic            busy;

  led_mode_sequencer #(
    .NUM_MODES       (NM),
    .PWM_PERIOD      (P),
    .FADE_STEPS      (S),
    .FADE_STEP_TICKS (T),
    .DWELL_TICKS     (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .auto_en      (auto_en),
    .mode_led     (mode_led),
    .led_out      (led_out),
    .mode_sel     (mode_sel),
    .mode_restart (mode_restart),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model: values held here describe the outputs after the last edge.
  // ---------------------------------------------------------------------------
  bit         m_valid = 1'b0;
  int         m_ph, m_el, m_sel, m_pend, m_dir, m_dwell, m_pwm;
  logic [7:0] m_led;

  initial begin
    forever begin
      @(posedge clk);
      begin
        int req, lvl;
        logic [7:0] drv;
        req = btn_next ? 1 : (btn_prev ? -1 : 0);
        if (rst) begin
          m_valid = 1'b1;
          m_ph = PH_IN; m_el = 0; m_sel = 0; m_pend = 0; m_dir = 0;
          m_dwell = 0; m_pwm = 0; m_led = 8'hFF;
        end else if (m_valid) begin
          case (m_ph)
            PH_RUN: begin
              if (req == 0 && auto_en && m_dwell == DW - 1) req = 1;
              if (req != 0) begin
                m_ph = PH_OUT; m_el = 0; m_dir = req; m_dwell = 0;
              end else begin
                m_dwell = auto_en ? m_dwell + 1 : 0;
              end
            end
            PH_OUT: begin
              if (req != 0) m_pend = req;
              m_el++;
              if (m_el == FADE_LEN) begin
                m_ph = PH_SWAP;
                m_sel = (m_sel + m_dir + NM) % NM;
              end
            end
            PH_SWAP: begin
              if (req != 0) m_pend = req;
              m_ph = PH_IN; m_el = 0;
            end
            default: begin
              if (req != 0) m_pend = req;
              m_el++;
              if (m_el == FADE_LEN) begin
                m_el = 0;
                if (m_pend != 0) begin
                  m_ph = PH_OUT; m_dir = m_pend; m_pend = 0;
                end else begin
                  m_ph = PH_RUN; m_dwell = 0;
                end
              end
            end
          endcase
          case (m_ph)
            PH_RUN:  lvl = S;
            PH_OUT:  lvl = S - m_el / T;
            PH_SWAP: lvl = 0;
            default: lvl = m_el / T;
          endcase
          drv   = mode_led[8*m_sel +: 8];
          m_led = (m_pwm < lvl * (P / S)) ? drv : 8'hFF;
          m_pwm = (m_pwm + 1) % P;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("led_out",      led_out,      m_led);
        check("mode_sel",     mode_sel,     m_sel);
        check("busy",         busy,         (m_ph != PH_RUN));
        check("mode_restart", mode_restart, (m_ph == PH_SWAP) ? (1 << m_sel) : 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change only at negedges)
  // ---------------------------------------------------------------------------
  // Pulse the buttons for one edge, then follow the crossfade to its SWAP cycle.
  // lat: edges from the sampling edge to the SWAP-entry edge.
  // lo : cycles with led_out[0] low while the model sits at level 2 of fade-out.
  task automatic press_and_swap(input logic nx, input logic pv, output int lat, output int lo);
    int n;
    btn_next = nx;
    btn_prev = pv;
    @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    n  = 1;
    lo = 0;
    while (mode_restart == '0 && n < 300) begin
      @(negedge clk);
      n++;
      if (n >= 33 && n <= 48 && led_out[0] == 1'b0) lo++;
    end
    lat = n - 1;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  int exp_sel [4] = '{1, 2, 3, 0};
  int exp_rst [4] = '{2, 4, 8, 1};
  int lat, lo, n, drops, dark_bad;

  initial begin
    rst      = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;
    mode_led = {8'h03, 8'h02, 8'h01, 8'h00};

    // 1. Reset for three edges, then fade in from dark.
    repeat (3) @(negedge clk);
    check("rst_led_out",      led_out,      8'hFF);
    check("rst_mode_sel",     mode_sel,     2'd0);
    check("rst_busy",         busy,         1'b1);
    check("rst_mode_restart", mode_restart, 4'b0000);
    rst = 1'b0;
    n = 0;
    dark_bad = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
      if (n <= T && led_out != 8'hFF) dark_bad++;
    end
    check("run_after_reset_cycles", n, 64);
    check("level0_dark_cycles_lit", dark_bad, 0);

    // 2. Four next presses with wrap.
    for (int i = 0; i < 4; i++) begin
      press_and_swap(1'b1, 1'b0, lat, lo);
      check("next_swap_latency", lat, 64);
      check("next_mode_sel", mode_sel, exp_sel[i]);
      check("next_mode_restart", mode_restart, exp_rst[i]);
      if (i == 0) check("level2_low_cycles", lo, 8);
      wait_idle(200, n);
      repeat (200 - 130) @(negedge clk);
    end

    // 3. Prev from mode 0 wraps to the last mode.
    press_and_swap(1'b0, 1'b1, lat, lo);
    check("prev_wrap_mode_sel", mode_sel, 2'd3);
    check("prev_wrap_restart", mode_restart, 4'b1000);
    wait_idle(200, n);

    // 4. Coincident buttons (next wins), then a prev queued during fade-in.
    press_and_swap(1'b1, 1'b1, lat, lo);
    check("coincident_mode_sel", mode_sel, 2'd0);
    check("coincident_restart", mode_restart, 4'b0001);
    repeat (10) @(negedge clk);
    btn_prev = 1'b1;
    @(negedge clk);
    btn_prev = 1'b0;
    n = 0;
    drops = 0;
    while (mode_restart == '0 && n < 300) begin
      @(negedge clk);
      n++;
      if (!busy) drops++;
    end
    check("pending_mode_sel", mode_sel, 2'd3);
    check("pending_restart", mode_restart, 4'b1000);
    check("pending_no_run_gap", drops, 0);
    wait_idle(200, n);

    // 5. Auto-advance after the dwell, then auto_en dropped before expiry.
    auto_en = 1'b1;
    n = 0;
    while (!busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("dwell_advance_cycles", n, 200);
    auto_en = 1'b0;
    wait_idle(200, n);
    check("auto_mode_sel", mode_sel, 2'd0);
    auto_en = 1'b1;
    drops = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy) drops++;
    end
    auto_en = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) drops++;
    end
    check("auto_dropped_no_advance", drops, 0);

    // 6. Random buttons, auto_en toggling and driver patterns.
    auto_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      btn_next = ($urandom_range(0, 199) == 0);
      btn_prev = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 99) == 0)  mode_led = $urandom;
    end
    @(negedge clk);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;
    mode_led = {8'h03, 8'h02, 8'h01, 8'h00};
    wait_idle(600, n);
    if (mode_sel == 2'd0) begin
      press_and_swap(1'b1, 1'b0, lat, lo);
      wait_idle(200, n);
    end

    // 7. Reset mid fade-out with a request pending: everything returns to reset values.
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    btn_prev = 1'b1;
    @(negedge clk);
    btn_prev = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midfade_rst_led_out",      led_out,      8'hFF);
    check("midfade_rst_mode_sel",     mode_sel,     2'd0);
    check("midfade_rst_busy",         busy,         1'b1);
    check("midfade_rst_mode_restart", mode_restart, 4'b0000);
    rst = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("pending_dropped_run_cycles", n, 64);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
